// File: rtl/ysyx_22050550_reg_scoreboard_pkg.sv
// Shared constants for the GPR write scoreboard.
// Register-file geometry and the pending-counter width.
package ysyx_22050550_reg_scoreboard_pkg;

    localparam int REG_NUM  = 32;
    localparam int REG_AW   = 5;
    localparam int SB_CNT_W = 2;

endpackage

// File: rtl/ysyx_22050550_sb_cnt.sv
// Saturating up/down counter of in-flight writes to one GPR.
// Simultaneous inc and dec cancel; clr wins over both.
module ysyx_22050550_sb_cnt
    import ysyx_22050550_reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt       = cnt_q;
    assign zero      = (cnt_q == '0);
    assign full      = &cnt_q;
    assign underflow = dec & ~inc & zero;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_22050550_reg_scoreboard.sv
// GPR write scoreboard: tracks in-flight writes per register and
// stalls IDU on RAW/WAW hazards the WBU bypass cannot cover.
module ysyx_22050550_reg_scoreboard
    import ysyx_22050550_reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int NREG  = REG_NUM
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_IDU_valid,
    input  logic              io_IDU_ren1,
    input  logic              io_IDU_ren2,
    input  logic [REG_AW-1:0] io_IDU_raddr1,
    input  logic [REG_AW-1:0] io_IDU_raddr2,
    input  logic              io_IDU_wen,
    input  logic [REG_AW-1:0] io_IDU_waddr,
    input  logic              io_IDU_fire,
    output logic              io_IDU_stall,
    input  logic              io_WBU_valid,
    input  logic [REG_AW-1:0] io_WBU_waddr,
    input  logic              io_flush,
    output logic [NREG-1:0]   io_busy_vec,
    output logic              io_err
);

    localparam int GW = CNT_W + 1;
    localparam logic [GW-1:0] GRACE = GW'(2 ** CNT_W);

    logic [NREG-1:0][CNT_W-1:0] cnt_w;
    logic [NREG-1:0]            zero_w;
    logic [NREG-1:0]            full_w;
    logic [NREG-1:0]            uf_w;

    logic [GW-1:0] grace_q;
    logic [GW-1:0] grace_d;
    logic          err_q;
    logic          err_d;

    logic issue;
    logic retire;
    logic pass1;
    logic pass2;
    logic raw1;
    logic raw2;
    logic waw_full;

    assign retire = io_WBU_valid & (io_WBU_waddr != '0);
    assign issue  = io_IDU_fire & io_IDU_wen
                  & (io_IDU_waddr != '0) & ~io_IDU_stall;

    assign cnt_w[0]  = '0;
    assign zero_w[0] = 1'b1;
    assign full_w[0] = 1'b0;
    assign uf_w[0]   = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        ysyx_22050550_sb_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (issue && io_IDU_waddr == REG_AW'(i)),
            .dec      (retire && io_WBU_waddr == REG_AW'(i)),
            .clr      (io_flush),
            .cnt      (cnt_w[i]),
            .zero     (zero_w[i]),
            .full     (full_w[i]),
            .underflow(uf_w[i])
        );
    end

    // A read is covered when WBU is writing back the only pending write.
    always_comb begin
        pass1 = io_WBU_valid & (io_WBU_waddr == io_IDU_raddr1)
              & (cnt_w[io_IDU_raddr1] == CNT_W'(1));
        pass2 = io_WBU_valid & (io_WBU_waddr == io_IDU_raddr2)
              & (cnt_w[io_IDU_raddr2] == CNT_W'(1));
        raw1 = io_IDU_ren1 & (io_IDU_raddr1 != '0)
             & ~zero_w[io_IDU_raddr1] & ~pass1;
        raw2 = io_IDU_ren2 & (io_IDU_raddr2 != '0)
             & ~zero_w[io_IDU_raddr2] & ~pass2;
        waw_full = io_IDU_wen & (io_IDU_waddr != '0)
                 & full_w[io_IDU_waddr]
                 & ~(retire & (io_WBU_waddr == io_IDU_waddr));
        io_IDU_stall = io_IDU_valid & (raw1 | raw2 | waw_full);
    end

    // Late retires of flushed writes are tolerated while grace runs.
    always_comb begin
        grace_d = grace_q;
        err_d   = err_q;
        if (io_flush) begin
            grace_d = GRACE;
        end else if (grace_q != '0) begin
            grace_d = grace_q - 1'b1;
        end
        if (io_IDU_fire && io_IDU_stall) begin
            err_d = 1'b1;
        end
        if ((|uf_w) && !io_flush && grace_q == '0) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grace_q <= '0;
            err_q   <= 1'b0;
        end else begin
            grace_q <= grace_d;
            err_q   <= err_d;
        end
    end

    assign io_busy_vec = ~zero_w;
    assign io_err      = err_q;

endmodule
